nap_countdown: RTL
==================

Name: nap_countdown

Overview:
- Downstream consumer of the shortcut time-setting stage.
- Latches the six BCD digits presented when settings complete, counts them down to 00:00:00 at one decrement per second, then raises the wake-up alarm.
- Drives the remaining-time display digits and the alarm/buzzer enable for the nap timer top level.

Parameters:
- TICK_DIV, 50000000: clk cycles per one-second tick from the internal prescaler. Legal values are ≥2.
- ALARM_SEC, 60: number of ticks the alarm stays asserted when not acknowledged. Legal values are ≥1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- load  input  1  one-cycle pulse; latch the *_in digits (driven by completeSetting)
- start_stop  input  1  one-cycle pulse; toggles between running and paused
- cancel  input  1  one-cycle pulse; abort and clear to idle
- ack  input  1  one-cycle pulse; silence the alarm
- hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in  input  4 each  BCD setting digits
- hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out  output  4 each  remaining time, registered BCD
- running  output  1  high in RUNNING
- alarm  output  1  high in ALARM
- done  output  1  one-cycle pulse on entry to ALARM

Behaviour:
- Reset (rst=0, async): all digits 0, state IDLE, prescaler 0, alarm counter 0, running=alarm=done=0.
- States: IDLE, LOADED, RUNNING, PAUSED, ALARM. All outputs are registered.
- Command priority when several pulses arrive in one cycle: cancel > ack > load > start_stop. Only the highest-priority applicable command acts.
- cancel, any state: digits cleared to 0, prescaler cleared, go to IDLE next cycle.
- ack: in ALARM, go to IDLE next cycle with digits held at 0. In other states it is ignored.
- load: accepted in IDLE, LOADED, RUNNING and PAUSED; ignored in ALARM.
  - Digits are captured on the next edge, with per-digit saturation: sec_ten and min_ten are clamped to 5; any other digit above 9 is clamped to 9.
  - Prescaler is cleared on load.
  - If the captured value is all zero, go to IDLE. Otherwise go to LOADED; a load during RUNNING also stops the count.
- start_stop:
  - LOADED→RUNNING and PAUSED→RUNNING.
  - RUNNING→PAUSED.
  - Ignored in IDLE and ALARM.
- Prescaler:
  - Counts only in RUNNING and ALARM; holds its value in PAUSED.
  - Entering RUNNING from LOADED starts from 0. Resuming from PAUSED continues from the held value.
  - tick is internal, asserted when prescaler = TICK_DIV-1; prescaler then wraps to 0.
  - First decrement therefore occurs TICK_DIV cycles after the start_stop edge.
- Decrement on tick in RUNNING, ripple-borrow BCD:
  - sec_one 0→9 borrows from sec_ten; sec_ten 0→5 borrows from min_one.
  - min_one 0→9 borrows from min_ten; min_ten 0→5 borrows from hour_one.
  - hour_one 0→9 borrows from hour_ten. Hours range 00-99.
- Terminal condition: a tick while the value is 00:00:01 writes 00:00:00, enters ALARM and pulses done, all on the same edge. The alarm counter is cleared on that edge.
- Zero never wraps: RUNNING is never entered or held with an all-zero value.
- ALARM:
  - alarm=1; the alarm counter increments on each tick.
  - When the counter reaches ALARM_SEC, go to IDLE; alarm drops on that edge.
- Reset mid-count: immediate return to reset values; no done pulse.

Test Plan:
- Run TICK_DIV=4, ALARM_SEC=3 throughout.
- Load 00:00:03, start_stop:
  - Digits show 02, 01, 00 at 4, 8 and 12 cycles after start.
  - done is high for exactly one cycle at cycle 12; alarm stays 1 for 12 more cycles, then IDLE.
- Load 10:00:00, start, one tick: output 09:59:59.
  - A second test from 01:00:00 shows 00:59:59 after one tick (full borrow chain).
- Pause/resume from 00:00:05:
  - Pause 2 cycles after start, hold 10 cycles, resume.
  - Next decrement lands 2 cycles after resume; digits stay frozen while PAUSED.
- Load with digits 00:7:C:9:F (min_ten=7, min_one=12, sec_ten=9, sec_one=15) → captured as 00:59:59. Load 00:00:00 → stays IDLE, running=0, and start_stop is ignored.
- Priority checks:
  - cancel+load in the same cycle while RUNNING → IDLE with all-zero digits.
  - ack in ALARM → IDLE next cycle.
  - load in ALARM → ignored.
- Assert rst=0 asynchronously mid-RUNNING at 00:00:02 → outputs zero immediately, no done; after release, start_stop is ignored (IDLE).

Source files
------------

// File: rtl/nap_countdown_if.sv
// Command, setting-digit and status bundle between the time-setting stage,
// the nap countdown core and the nap timer top level.
interface nap_countdown_if;
  logic       load;
  logic       start_stop;
  logic       cancel;
  logic       ack;

  logic [3:0] hour_ten_in;
  logic [3:0] hour_one_in;
  logic [3:0] min_ten_in;
  logic [3:0] min_one_in;
  logic [3:0] sec_ten_in;
  logic [3:0] sec_one_in;

  logic [3:0] hour_ten_out;
  logic [3:0] hour_one_out;
  logic [3:0] min_ten_out;
  logic [3:0] min_one_out;
  logic [3:0] sec_ten_out;
  logic [3:0] sec_one_out;

  logic       running;
  logic       alarm;
  logic       done;

  modport master (
    output load, start_stop, cancel, ack,
    output hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in,
    input  hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out,
    input  running, alarm, done
  );

  modport slave (
    input  load, start_stop, cancel, ack,
    input  hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in,
    output hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out,
    output running, alarm, done
  );
endinterface

// File: rtl/nap_countdown.sv
// Nap timer countdown: latches six BCD digits, counts down once per second
// to 00:00:00, then holds the wake-up alarm for ALARM_SEC seconds.
module nap_countdown #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned ALARM_SEC = 60
) (
  input  logic             clk,
  input  logic             rst,
  nap_countdown_if.slave   bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned AW = $clog2(ALARM_SEC + 1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOADED = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_PAUSED = 3'd3;
  localparam logic [2:0] S_ALARM  = 3'd4;

  // Digit index 0 is sec_one, 5 is hour_ten.
  logic [2:0]       state_q, state_d;
  logic [5:0][3:0]  dig_q, dig_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [AW-1:0]    acnt_q, acnt_d;
  logic             running_q, alarm_q, done_q;

  logic [5:0][3:0]  load_dig;
  logic [5:0][3:0]  dec_dig;
  logic [AW-1:0]    acnt_inc;
  logic             counting;
  logic             tick;
  logic             at_one;
  logic             borrow;

  function automatic logic [3:0] sat(input logic [3:0] d, input logic [3:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  function automatic logic [3:0] digit_max(input logic [2:0] idx);
    return (idx == 3'd1 || idx == 3'd3) ? 4'd5 : 4'd9;
  endfunction

  assign load_dig = {sat(bus.hour_ten_in, 4'd9), sat(bus.hour_one_in, 4'd9),
                     sat(bus.min_ten_in,  4'd5), sat(bus.min_one_in,  4'd9),
                     sat(bus.sec_ten_in,  4'd5), sat(bus.sec_one_in,  4'd9)};

  assign counting = (state_q == S_RUN) || (state_q == S_ALARM);
  assign tick     = counting && (pre_q == PRE_LAST);
  assign at_one   = (dig_q == 24'd1);
  assign acnt_inc = acnt_q + AW'(1);

  // Ripple-borrow decrement; each digit wraps to its own maximum while borrowing.
  always_comb begin
    dec_dig = dig_q;
    borrow  = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      if (borrow) begin
        if (dec_dig[3'(i)] == 4'd0) begin
          dec_dig[3'(i)] = digit_max(3'(i));
        end else begin
          dec_dig[3'(i)] = dec_dig[3'(i)] - 4'd1;
          borrow         = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    pre_d   = pre_q;
    acnt_d  = acnt_q;

    if (counting) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
    end

    if (state_q == S_RUN && tick) begin
      if (at_one) begin
        dig_d   = '0;
        state_d = S_ALARM;
        acnt_d  = '0;
      end else begin
        dig_d = dec_dig;
      end
    end else if (state_q == S_ALARM && tick) begin
      acnt_d = acnt_inc;
      if (acnt_inc == ALARM_LAST) begin
        state_d = S_IDLE;
      end
    end

    // Commands override the tick result; only the highest-priority one acts.
    if (bus.cancel) begin
      state_d = S_IDLE;
      dig_d   = '0;
      pre_d   = '0;
      acnt_d  = '0;
    end else if (bus.ack && state_q == S_ALARM) begin
      state_d = S_IDLE;
      dig_d   = '0;
      pre_d   = '0;
      acnt_d  = '0;
    end else if (bus.load && state_q != S_ALARM) begin
      dig_d   = load_dig;
      pre_d   = '0;
      state_d = (load_dig == '0) ? S_IDLE : S_LOADED;
    end else if (bus.start_stop) begin
      case (state_q)
        S_LOADED: begin
          state_d = S_RUN;
          pre_d   = '0;
        end
        S_PAUSED: state_d = S_RUN;
        S_RUN: begin
          if (state_d == S_RUN) begin
            state_d = S_PAUSED;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      dig_q     <= '0;
      pre_q     <= '0;
      acnt_q    <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dig_q     <= dig_d;
      pre_q     <= pre_d;
      acnt_q    <= acnt_d;
      running_q <= (state_d == S_RUN);
      alarm_q   <= (state_d == S_ALARM);
      done_q    <= (state_d == S_ALARM) && (state_q != S_ALARM);
    end
  end

  assign bus.sec_one_out  = dig_q[0];
  assign bus.sec_ten_out  = dig_q[1];
  assign bus.min_one_out  = dig_q[2];
  assign bus.min_ten_out  = dig_q[3];
  assign bus.hour_one_out = dig_q[4];
  assign bus.hour_ten_out = dig_q[5];
  assign bus.running      = running_q;
  assign bus.alarm        = alarm_q;
  assign bus.done         = done_q;

endmodule
